// File: rtl/retire_multi.sv
// In-order retirement stage: reorder buffer retiring up to RETIRE_WIDTH entries per cycle,
// a blocking data-memory port for the head load/store, and branch-mispredict flush.
module retire_multi #(
  parameter int ROB_DEPTH    = 16,
  parameter int RETIRE_WIDTH = 2,
  parameter int PREG_W       = 6,
  parameter int XLEN         = 32,
  localparam int TAG_W       = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  // valid/ready: a transfer happens on a rising edge where both are high; valid may not
  // depend on ready, ready drops while full or while a flush is being signalled.
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [1:0]                     alloc_kind,
  input  logic [2:0]                     alloc_funct3,
  input  logic [PREG_W-1:0]              alloc_dest,
  input  logic [PREG_W-1:0]              alloc_old,
  output logic [TAG_W-1:0]               alloc_tag,
  input  logic                           wb_valid,
  input  logic [TAG_W-1:0]               wb_tag,
  input  logic [XLEN-1:0]                wb_value,
  input  logic [31:0]                    wb_addr,
  input  logic                           wb_mispredict,
  output logic [RETIRE_WIDTH-1:0]        rf_wr_en,
  output logic [RETIRE_WIDTH*PREG_W-1:0] rf_wr_addr,
  output logic [RETIRE_WIDTH*XLEN-1:0]   rf_wr_data,
  output logic [RETIRE_WIDTH-1:0]        free_en,
  output logic [RETIRE_WIDTH*PREG_W-1:0] free_reg,
  output logic                           dmem_req,
  output logic [3:0]                     dmem_we,
  output logic [31:0]                    dmem_addr,
  output logic [31:0]                    dmem_wdata,
  input  logic                           dmem_ack,
  input  logic [31:0]                    dmem_rdata,
  output logic                           flush,
  output logic [31:0]                    flush_pc,
  output logic [TAG_W:0]                 count,
  output logic [1:0]                     dbg_mem_state
);

  localparam logic [1:0] KIND_ALU   = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;
  localparam logic [1:0] KIND_BR    = 2'b11;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_DONE} mem_state_t;

  mem_state_t mem_state;

  logic [TAG_W:0]      head, tail, occupancy, n_ret;
  logic [TAG_W-1:0]    head_idx, tail_idx, wb_dist, ret_slot;
  logic                full, wb_hit, alloc_fire, chain, head_is_mem;
  logic [RETIRE_WIDTH-1:0] retire;
  logic [XLEN-1:0]     load_data;

  logic [ROB_DEPTH-1:0] e_done;
  logic [1:0]           e_kind   [ROB_DEPTH];
  logic [2:0]           e_funct3 [ROB_DEPTH];
  logic [PREG_W-1:0]    e_dest   [ROB_DEPTH];
  logic [PREG_W-1:0]    e_old    [ROB_DEPTH];
  logic [XLEN-1:0]      e_value  [ROB_DEPTH];
  logic [31:0]          e_addr   [ROB_DEPTH];
  logic                 e_misp   [ROB_DEPTH];

  function automatic logic [3:0] store_be(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b0001;
      3'b001:  return 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'b000:  return {{(XLEN-8){r[7]}}, r[7:0]};
      3'b001:  return {{(XLEN-16){r[15]}}, r[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, r[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, r[15:0]};
      default: return XLEN'(r);
    endcase
  endfunction

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign occupancy   = tail - head;
  assign count       = occupancy;
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_idx;
  // Write-backs only land on entries between head and tail.
  assign wb_dist     = wb_tag - head_idx;
  assign wb_hit      = wb_valid && ({1'b0, wb_dist} < occupancy);
  assign head_is_mem = (occupancy != '0) && e_done[head_idx] &&
                       ((e_kind[head_idx] == KIND_LOAD) || (e_kind[head_idx] == KIND_STORE));
  assign dbg_mem_state = mem_state;

  always_comb begin
    retire     = '0;
    rf_wr_en   = '0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    free_en    = '0;
    free_reg   = '0;
    flush      = 1'b0;
    flush_pc   = '0;
    n_ret      = '0;
    ret_slot   = head_idx;
    chain      = (mem_state == MEM_IDLE);
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      ret_slot = head_idx + TAG_W'(i);
      if (chain && (occupancy > (TAG_W+1)'(i)) && e_done[ret_slot] &&
          ((e_kind[ret_slot] == KIND_ALU) || ((e_kind[ret_slot] == KIND_BR) && (i == 0)))) begin
        retire[i] = 1'b1;
        if ((e_kind[ret_slot] == KIND_ALU) && (e_dest[ret_slot] != '0)) begin
          rf_wr_en[i]                     = 1'b1;
          rf_wr_addr[i*PREG_W +: PREG_W]  = e_dest[ret_slot];
          rf_wr_data[i*XLEN +: XLEN]      = e_value[ret_slot];
          free_en[i]                      = 1'b1;
          free_reg[i*PREG_W +: PREG_W]    = e_old[ret_slot];
        end
        if ((e_kind[ret_slot] == KIND_BR) && e_misp[ret_slot]) begin
          flush    = 1'b1;
          flush_pc = 32'(e_value[ret_slot]);
        end
      end
      // A branch closes the group; only ALU entries let the next slot follow.
      chain = retire[i] && (e_kind[ret_slot] == KIND_ALU);
    end
    if (mem_state == MEM_DONE) begin
      retire[0] = 1'b1;
      if ((e_kind[head_idx] == KIND_LOAD) && (e_dest[head_idx] != '0)) begin
        rf_wr_en[0]             = 1'b1;
        rf_wr_addr[PREG_W-1:0]  = e_dest[head_idx];
        rf_wr_data[XLEN-1:0]    = load_data;
        free_en[0]              = 1'b1;
        free_reg[PREG_W-1:0]    = e_old[head_idx];
      end
    end
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      n_ret = n_ret + (TAG_W+1)'(retire[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      // The mispredicted branch retires and everything younger is discarded.
      head <= head + (TAG_W+1)'(1);
      tail <= head + (TAG_W+1)'(1);
    end else begin
      head <= head + n_ret;
      if (alloc_fire) tail <= tail + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_done <= '0;
    end else begin
      if (wb_hit)     e_done[wb_tag]   <= 1'b1;
      if (alloc_fire) e_done[tail_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      e_kind[tail_idx]   <= alloc_kind;
      e_funct3[tail_idx] <= alloc_funct3;
      e_dest[tail_idx]   <= alloc_dest;
      e_old[tail_idx]    <= alloc_old;
    end
    if (wb_hit) begin
      e_value[wb_tag] <= wb_value;
      e_addr[wb_tag]  <= wb_addr;
      e_misp[wb_tag]  <= wb_mispredict;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_state  <= MEM_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
    end else begin
      case (mem_state)
        MEM_IDLE: begin
          if (head_is_mem) begin
            mem_state  <= MEM_REQ;
            dmem_req   <= 1'b1;
            dmem_addr  <= e_addr[head_idx];
            dmem_wdata <= 32'(e_value[head_idx]);
            dmem_we    <= (e_kind[head_idx] == KIND_STORE) ? store_be(e_funct3[head_idx]) : 4'b0000;
          end
        end
        MEM_REQ: begin
          if (dmem_ack) begin
            mem_state <= MEM_DONE;
            dmem_req  <= 1'b0;
            load_data <= load_extend(e_funct3[head_idx], dmem_rdata);
          end
        end
        MEM_DONE: mem_state <= MEM_IDLE;
        default:  mem_state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/retire_multi.md
RETIRE_MULTI -- requirements
Module: retire_multi

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of reorder-buffer entries; SHALL be a power of two, at least 4.
REQ-002 Parameter RETIRE_WIDTH, default 2, maximum entries retired per cycle; legal values are 1 and 2.
REQ-003 Parameter PREG_W, default 6, physical-register address width. Parameter XLEN, default 32, data width. TAG_W = log2(ROB_DEPTH).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 alloc_valid / alloc_ready  in/out  1/1  allocation handshake; an entry is allocated when both are high.
REQ-007 alloc_kind  in  2  entry kind: 00 ALU, 01 load, 10 store, 11 branch.
REQ-008 alloc_funct3  in  3  load/store size field. alloc_dest, alloc_old  in  PREG_W  destination register and previous mapping.
REQ-009 alloc_tag  out  TAG_W  index of the entry that the next allocation will use.
REQ-010 wb_valid, wb_tag, wb_value(XLEN), wb_addr(32), wb_mispredict  in  completion port; marks one entry done.
REQ-011 rf_wr_en[RETIRE_WIDTH], rf_wr_addr[RETIRE_WIDTH*PREG_W], rf_wr_data[RETIRE_WIDTH*XLEN]  out  register-file writes.
REQ-012 free_en[RETIRE_WIDTH], free_reg[RETIRE_WIDTH*PREG_W]  out  old physical registers returned to the free list.
REQ-013 dmem_req, dmem_we(4), dmem_addr(32), dmem_wdata(32)  out; dmem_ack, dmem_rdata(32)  in  data-memory handshake.
REQ-014 flush, flush_pc(32)  out  mispredict redirect. count  out  TAG_W+1  number of occupied entries.

Function
REQ-015 Head and tail pointers SHALL each be TAG_W+1 bits. Empty when the pointers are equal; full when the low bits match and the MSBs differ.
REQ-016 alloc_ready = !full && !flush. An allocation writes the entry with done=0 and advances the tail by 1, wrapping modulo ROB_DEPTH.
REQ-017 A write-back SHALL set done=1 and store value, addr and mispredict in entry wb_tag. A write-back to a non-allocated entry is ignored.
REQ-018 The retire candidates are slots head+0 .. head+RETIRE_WIDTH-1.
REQ-019 Slot i retires only if it is occupied, done, every lower slot retires in the same cycle, and it is not a load or store.
REQ-020 A branch may retire only in slot 0, and it stops the group after itself.
REQ-021 An ALU entry retiring with alloc_dest != 0 asserts rf_wr_en[i] and free_en[i] in the same cycle, combinationally from the current state (0-cycle latency).
REQ-022 A branch retiring with mispredict=1 asserts flush for exactly 1 cycle with flush_pc = value.
REQ-023 On the following edge a mispredict flush sets the tail to head+1, empties the buffer and discards any same-cycle allocation.
REQ-024 Memory FSM states: IDLE, REQ, DONE.
- IDLE -> REQ when slot 0 is a done load or store.
- REQ holds dmem_req=1 with stable addr/we/wdata until dmem_ack is sampled high, then -> DONE.
- DONE retires the entry alone (slot 0 only), then returns to IDLE.
REQ-025 Store byte enables: SB 0001, SH 0011, SW 1111; any other funct3 gives 0000 and the store still retires.
REQ-026 Load data is captured on ack and extended per funct3: LB/LBU 8-bit, LH/LHU 16-bit, sign- or zero-extended; LW unchanged.
REQ-027 If an allocation and a retire occur in the same cycle, count = count + 1 - retired.
REQ-028 Pointer wrap-around SHALL be seamless; retiring slot head+1 across index ROB_DEPTH-1 -> 0 is legal.

Reset
REQ-029 Reset asserted: head=tail=0, all done bits 0, FSM=IDLE, and every output enable (rf_wr_en, free_en, dmem_req, flush) is 0. count=0, alloc_ready=1 once reset is released.
REQ-030 Reset asserted mid-transaction SHALL abandon the memory request immediately; an ack arriving after reset is ignored.

Verification
REQ-031 Allocate 2 ALU entries with dest 5 and 6, write both back (0xA, 0xB) -> next cycle rf_wr_en=11, addresses 5/6, data 0xA/0xB, count 2 -> 0.
REQ-032 Allocate 16 entries with no write-backs -> alloc_ready=0 and count=16; retire one -> alloc_ready=1.
REQ-033 SH store to addr 0x100, dmem_ack delayed 3 cycles -> dmem_req high for 3 cycles, dmem_we=0011, retires on the cycle after ack.
REQ-034 LB load, rdata=0x000000F0 -> rf_wr_data=0xFFFFFFF0; the same with LBU -> 0x000000F0.
REQ-035 Branch with mispredict=1, flush_pc=0x40, and 3 younger entries -> flush pulses 1 cycle, count=0 next cycle, younger entries are never written.
REQ-036 Fill to depth 16, drain, refill to index 15 -> wrap, then dual-retire across indices 15 and 0 -> both retire in one cycle.
